// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative radix-2 divider.
package iter_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, select.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    diff    = shifted - {1'b0, dvs_i};
    // Bit WIDTH of the difference is the borrow: set means the trial went negative.
    qbit_o  = ~diff[WIDTH];
    rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned integer divider (DIV/DIVU), fixed WIDTH+2 cycle latency.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_q, sgn_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic             dz_now;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    dz_now  = (dvs_q == '0);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sgn_d   = is_signed;
          a_neg_d = is_signed & dividend[WIDTH-1];
          b_neg_d = is_signed & divisor[WIDTH-1];
          dvd_d   = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
          dvs_d   = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The dividend register doubles as the quotient: bits leave at the top, quotient bits enter at the bottom.
        if (cnt_q == CW'(WIDTH)) begin
          state_d = S_FIX;
        end else begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        // A zero divisor leaves all quotient bits set and |dividend| in the remainder; keep the all-ones quotient.
        quo_d   = (sgn_q & (a_neg_q ^ b_neg_q) & ~dz_now) ? -dvd_q : dvd_q;
        remo_d  = (sgn_q & a_neg_q) ? -rem_q : rem_q;
        dz_d    = dz_now;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed-vector bench for iter_divider (WIDTH = 32).
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_vec = 0;
  int n_bad = 0;

  iter_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, then wait (bounded) for done; lat counts edges after the accepting edge.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op_vec(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int lat;
    run_op(s, a, b, lat);
    chk({tag, " latency"}, 32'(lat), 32'd34);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
    chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    chk({tag, " quotient hold"}, quotient, eq);
  endtask

  initial begin
    int lat;
    int ndone;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    // start together with reset must be ignored
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset busy", {31'd0, busy}, 32'd0);

    op_vec("u100/7",      1'b0, 32'd100,      32'd7,          32'd14,       32'd2,        1'b0);
    op_vec("s-7/2",       1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    op_vec("s7/-2",       1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD, 32'd1,        1'b0);
    op_vec("s-100/-7",    1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,       32'hFFFFFFFE, 1'b0);
    op_vec("u/0",         1'b0, 32'h12345678, 32'd0,          32'hFFFFFFFF, 32'h12345678, 1'b1);
    op_vec("s-5/0",       1'b1, 32'hFFFFFFFB, 32'd0,          32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
    op_vec("s min/-1",    1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000, 32'd0,        1'b0);
    op_vec("u min/max",   1'b0, 32'h80000000, 32'hFFFFFFFF,   32'd0,        32'h80000000, 1'b0);
    op_vec("u max/16",    1'b0, 32'hFFFFFFFF, 32'd16,         32'h0FFFFFFF, 32'd15,       1'b0);

    // Second start during RUN with new operands: ignored, one done, first result.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; is_signed = 1'b1; dividend = 32'd55; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0; dividend = 32'd999; divisor = 32'd1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ndone++;
        chk("ignore-start quotient", quotient, 32'd14);
        chk("ignore-start remainder", remainder, 32'd2);
      end
      @(negedge clk);
    end
    chk("ignore-start done count", 32'(ndone), 32'd1);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd77; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset done", {31'd0, done}, 32'd0);
    chk("mid reset quotient", quotient, 32'd0);
    chk("mid reset remainder", remainder, 32'd0);
    chk("mid reset dz", {31'd0, div_by_zero}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("no done after reset", 32'(ndone), 32'd0);
    op_vec("u1000/10 after reset", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
